// File: rtl/sb_lsu.sv
// Load/store unit: buffers stores in a small FIFO, drains them over a single-outstanding
// req/ack bus, and services loads (after all earlier stores) with lane extraction and extension.
//
// state   | meaning
// IDLE    | no transfer; decides between draining stores and starting a load
// DRAIN   | presenting the FIFO head as a bus write
// LD_WAIT | load pending; draining buffered stores first
// LD_REQ  | bus read in flight for the pending load
module sb_lsu #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_re,
  input  logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        byte_sel,
  input  logic              un_sign,
  output logic              hold_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] rd_wdata_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LD_WAIT, LD_REQ} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-3:0] fifo_addr_q [DEPTH];
  logic [3:0]        fifo_strb_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              load_valid_q, misalign_q;
  logic [DATA_W-1:0] rd_wdata_q;

  function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] a);
    case (sel)
      4'b0001: return 1'b0;
      4'b0011: return a[0];
      4'b1111: return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  logic mis_w, mis_r, store_ok, load_req;
  logic full, empty, wr_active, rd_active, push, pop;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data, ld_sh, ld_ext;

  assign mis_w    = is_misaligned(byte_sel, mem_waddr[1:0]);
  assign mis_r    = is_misaligned(byte_sel, mem_raddr[1:0]);
  assign store_ok = mem_we & ~mis_w;
  // A simultaneous store wins; the read request is ignored that cycle.
  assign load_req = mem_re & ~mem_we & ~mis_r;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_active = (state_q == DRAIN) || ((state_q == LD_WAIT) && !empty);
  assign rd_active = (state_q == LD_REQ);
  assign pop       = wr_active & bus_ack_i;
  assign push      = store_ok & (~full | pop);

  assign st_strb = byte_sel << mem_waddr[1:0];
  assign st_data = mem_wdata << {mem_waddr[1:0], 3'b000};

  assign ld_sh = bus_rdata_i >> {mem_raddr[1:0], 3'b000};
  always_comb begin
    ld_ext = ld_sh;
    case (byte_sel)
      4'b0001: ld_ext = {{(DATA_W-8){~un_sign & ld_sh[7]}}, ld_sh[7:0]};
      4'b0011: ld_ext = {{(DATA_W-16){~un_sign & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      rd_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      load_valid_q <= rd_active & bus_ack_i;
      if (rd_active && bus_ack_i) rd_wdata_q <= ld_ext;
      misalign_q   <= (mem_we & mis_w) |
                      (~mem_we & mem_re & mis_r & (state_q == IDLE) & ~load_valid_q);
    end
  end

  // Payload storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_waddr[ADDR_W-1:2];
      fifo_strb_q[wr_ptr_q] <= st_strb;
      fifo_data_q[wr_ptr_q] <= st_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_req && !load_valid_q) state_d = empty ? LD_REQ : LD_WAIT;
        else if (!empty)               state_d = DRAIN;
      end
      DRAIN:   if (bus_ack_i)        state_d = IDLE;
      LD_WAIT: if (empty && !push)   state_d = LD_REQ;
      LD_REQ:  if (bus_ack_i)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The load stall starts combinationally on first sight of mem_re and ends after the read ack.
  assign hold_o = (store_ok & full & ~pop) |
                  (load_req & ~load_valid_q & (state_q == IDLE)) |
                  (state_q == LD_WAIT) | (state_q == LD_REQ);

  assign load_valid_o = load_valid_q;
  assign rd_wdata_o   = rd_wdata_q;
  assign misalign_o   = misalign_q;

  assign bus_req_o   = wr_active | rd_active;
  assign bus_we_o    = wr_active;
  assign bus_addr_o  = wr_active ? {fifo_addr_q[rd_ptr_q], 2'b00} :
                       rd_active ? {mem_raddr[ADDR_W-1:2], 2'b00} : '0;
  assign bus_wstrb_o = wr_active ? fifo_strb_q[rd_ptr_q] : 4'b0000;
  assign bus_wdata_o = wr_active ? fifo_data_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sb_lsu.sv
// Directed bench for sb_lsu: a small bus memory with programmable ack latency plus
// per-scenario tasks with hand-computed expectations.
module tb_sb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we, un_sign;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [3:0]  byte_sel;
  logic        hold_o, load_valid_o, misalign_o;
  logic [31:0] rd_wdata_o;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_wstrb_o;

  int pass_cnt = 0;
  int total    = 0;

  sb_lsu #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .byte_sel(byte_sel), .un_sign(un_sign),
    .hold_o(hold_o), .load_valid_o(load_valid_o), .rd_wdata_o(rd_wdata_o),
    .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Bus memory model and transfer log
  logic [31:0] tbmem [0:63];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        log_we   [0:63];
  logic [31:0] log_addr [0:63];
  logic [3:0]  log_strb [0:63];
  logic [31:0] log_data [0:63];
  int          log_n    = 0;
  int          stab_err = 0;
  logic        prev_valid = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_strb;

  assign bus_rdata_i = bus_req_o ? tbmem[bus_addr_o[7:2]] : 32'h0;

  always @(negedge clk) begin
    if (bus_req_o) begin
      if (wait_cnt >= ack_delay) bus_ack_i = 1'b1;
      else begin bus_ack_i = 1'b0; wait_cnt++; end
    end else begin
      bus_ack_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst) prev_valid = 1'b0;
    else begin
      if (prev_valid && bus_req_o &&
          (bus_we_o !== prev_we || bus_addr_o !== prev_addr ||
           bus_strb_mismatch() || bus_wdata_o !== prev_data))
        stab_err++;
      if (bus_req_o && bus_ack_i) begin
        if (log_n < 64) begin
          log_we[log_n]   = bus_we_o;
          log_addr[log_n] = bus_addr_o;
          log_strb[log_n] = bus_wstrb_o;
          log_data[log_n] = bus_wdata_o;
        end
        log_n++;
        if (bus_we_o)
          for (int b = 0; b < 4; b++)
            if (bus_wstrb_o[b]) tbmem[bus_addr_o[7:2]][8*b +: 8] = bus_wdata_o[8*b +: 8];
        wait_cnt = 0;
      end
      prev_valid = bus_req_o && !bus_ack_i;
      prev_we    = bus_we_o;
      prev_addr  = bus_addr_o;
      prev_strb  = bus_wstrb_o;
      prev_data  = bus_wdata_o;
    end
  end

  function automatic logic bus_strb_mismatch();
    return bus_wstrb_o !== prev_strb;
  endfunction

  task automatic test_reset();
    int seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({hold_o, load_valid_o, misalign_o, bus_req_o, bus_we_o} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000", {hold_o, load_valid_o, misalign_o, bus_req_o, bus_we_o});
    else pass_cnt++;
    total++; if ({rd_wdata_o, bus_addr_o, bus_wdata_o, bus_wstrb_o} !== 100'b0)
      $display("FAIL reset_data rd=%h addr=%h wd=%h strb=%b want 0", rd_wdata_o, bus_addr_o, bus_wdata_o, bus_wstrb_o);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); #1; if (bus_req_o || hold_o || load_valid_o || misalign_o) seen++; end
    total++; if (seen !== 0) $display("FAIL reset_idle activity_cycles=%0d want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_sb();
    int base = log_n;
    int seen = 0;
    ack_delay = 2;
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 32'h5; mem_wdata = 32'hA5; byte_sel = 4'b0001;
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL sb_hold got %b want 0", hold_o); else pass_cnt++;
    @(negedge clk); mem_we = 1'b0;
    for (int i = 0; i < 20 && log_n == base; i++) @(negedge clk);
    total++; if (log_n !== base + 1) $display("FAIL sb_count got %0d want %0d", log_n - base, 1);
    else pass_cnt++;
    total++; if ({log_we[base], log_addr[base], log_strb[base], log_data[base]} !== {1'b1, 32'h4, 4'b0010, 32'h0000_A500})
      $display("FAIL sb_bus we=%b addr=%h strb=%b wd=%h want 1/00000004/0010/0000a500",
               log_we[base], log_addr[base], log_strb[base], log_data[base]);
    else pass_cnt++;
    repeat (4) begin @(negedge clk); #1; if (bus_req_o) seen++; end
    total++; if (seen !== 0) $display("FAIL sb_empty req_cycles=%0d want 0", seen); else pass_cnt++;
  endtask

  task automatic test_lh(input logic us, input logic [31:0] exp);
    int base = log_n;
    int seen = 0;
    int hold_drop = 0;
    ack_delay = 1;
    @(negedge clk);
    mem_re = 1'b1; mem_raddr = 32'h2; byte_sel = 4'b0011; un_sign = us;
    #1;
    total++; if (hold_o !== 1'b1) $display("FAIL lh_hold_first got %b want 1", hold_o); else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (load_valid_o) begin seen = 1; break; end
      if (!hold_o) hold_drop++;
    end
    total++; if (seen !== 1) $display("FAIL lh_valid_timeout us=%b got %0d want 1", us, seen); else pass_cnt++;
    total++; if (rd_wdata_o !== exp) $display("FAIL lh_data us=%b got %h want %h", us, rd_wdata_o, exp);
    else pass_cnt++;
    total++; if ({hold_o, hold_drop} !== {1'b0, 32'd0})
      $display("FAIL lh_hold us=%b valid_cycle_hold=%b early_drops=%0d want 0/0", us, hold_o, hold_drop);
    else pass_cnt++;
    total++; if (log_n !== base + 1 || log_we[base] !== 1'b0 || log_addr[base] !== 32'h0)
      $display("FAIL lh_bus n=%0d we=%b addr=%h want 1/0/00000000", log_n - base, log_we[base], log_addr[base]);
    else pass_cnt++;
    mem_re = 1'b0;
    @(negedge clk); #1;
    total++; if (load_valid_o !== 1'b0) $display("FAIL lh_pulse got %b want 0", load_valid_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int base = log_n;
    int bad  = 0;
    ack_delay = 1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_we = 1'b1; mem_waddr = 32'h40 + 32'(4*i); mem_wdata = 32'h1111_0000 + 32'(i); byte_sel = 4'b1111;
      #1; if (hold_o !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL b2b_accept held=%0d want 0", bad); else pass_cnt++;
    @(negedge clk);
    mem_waddr = 32'h50; mem_wdata = 32'h1111_0004;
    #1;
    total++; if (hold_o !== 1'b1) $display("FAIL b2b_full_hold got %b want 1", hold_o); else pass_cnt++;
    @(negedge clk); #1;
    total++; if ({hold_o, bus_ack_i} !== 2'b10) $display("FAIL b2b_still_hold hold/ack=%b want 10", {hold_o, bus_ack_i});
    else pass_cnt++;
    ack_delay = 0;
    @(negedge clk); #1;
    total++; if ({hold_o, bus_ack_i} !== 2'b01) $display("FAIL b2b_ack_release hold/ack=%b want 01", {hold_o, bus_ack_i});
    else pass_cnt++;
    @(negedge clk); mem_we = 1'b0;
    for (int i = 0; i < 40 && log_n < base + 5; i++) @(negedge clk);
    total++; if (log_n !== base + 5) $display("FAIL b2b_count got %0d want 5", log_n - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== 32'h40 + 32'(4*i) ||
          log_data[base+i] !== 32'h1111_0000 + 32'(i) || log_strb[base+i] !== 4'b1111) begin
        bad++;
        $display("FAIL b2b_order idx=%0d got addr=%h data=%h want addr=%h data=%h",
                 i, log_addr[base+i], log_data[base+i], 32'h40 + 32'(4*i), 32'h1111_0000 + 32'(i));
      end
    total++; if (bad == 0) pass_cnt++;
    total++; if (stab_err !== 0) $display("FAIL bus_stable changes=%0d want 0", stab_err); else pass_cnt++;
  endtask

  task automatic test_sw_lw();
    int base = log_n;
    int seen = 0;
    ack_delay = 3;
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 32'h10; mem_wdata = 32'hDEAD_BEEF; byte_sel = 4'b1111;
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL swlw_st_hold got %b want 0", hold_o); else pass_cnt++;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b1; mem_raddr = 32'h10; un_sign = 1'b0;
    #1;
    total++; if (hold_o !== 1'b1) $display("FAIL swlw_ld_hold got %b want 1", hold_o); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (load_valid_o) begin seen = 1; break; end
    end
    total++; if (seen !== 1) $display("FAIL swlw_timeout got %0d want 1", seen); else pass_cnt++;
    total++; if (rd_wdata_o !== 32'hDEAD_BEEF) $display("FAIL swlw_data got %h want deadbeef", rd_wdata_o);
    else pass_cnt++;
    total++; if (log_n !== base + 2 || {log_we[base], log_addr[base]} !== {1'b1, 32'h10} ||
                 {log_we[base+1], log_addr[base+1]} !== {1'b0, 32'h10})
      $display("FAIL swlw_order n=%0d first=%b/%h second=%b/%h want 2 1/10 0/10", log_n - base,
               log_we[base], log_addr[base], log_we[base+1], log_addr[base+1]);
    else pass_cnt++;
    mem_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    int seen = 0;
    int base = log_n;
    @(negedge clk);
    mem_re = 1'b1; mem_raddr = 32'h3; byte_sel = 4'b1111;
    #1;
    total++; if ({hold_o, bus_req_o} !== 2'b00) $display("FAIL mis_lw_hold hold/req=%b want 00", {hold_o, bus_req_o});
    else pass_cnt++;
    @(negedge clk); mem_re = 1'b0; #1;
    total++; if (misalign_o !== 1'b1) $display("FAIL mis_lw_pulse got %b want 1", misalign_o); else pass_cnt++;
    @(negedge clk); #1;
    total++; if ({misalign_o, bus_req_o} !== 2'b00) $display("FAIL mis_lw_end mis/req=%b want 00", {misalign_o, bus_req_o});
    else pass_cnt++;
    mem_we = 1'b1; mem_waddr = 32'h1; mem_wdata = 32'h1234; byte_sel = 4'b0011;
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL mis_sh_hold got %b want 0", hold_o); else pass_cnt++;
    @(negedge clk); mem_we = 1'b0; #1;
    total++; if (misalign_o !== 1'b1) $display("FAIL mis_sh_pulse got %b want 1", misalign_o); else pass_cnt++;
    mem_re = 1'b1; mem_raddr = 32'h0; byte_sel = 4'b0101;
    @(negedge clk); mem_re = 1'b0; #1;
    total++; if (misalign_o !== 1'b1) $display("FAIL mis_sel_pulse got %b want 1", misalign_o); else pass_cnt++;
    repeat (4) begin @(negedge clk); #1; if (bus_req_o) seen++; end
    total++; if (seen !== 0 || log_n !== base) $display("FAIL mis_no_access req_cycles=%0d xfers=%0d want 0/0", seen, log_n - base);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int base = log_n;
    int seen = 0;
    int reached = 0;
    ack_delay = 1000;
    @(negedge clk);
    mem_re = 1'b1; mem_raddr = 32'h10; byte_sel = 4'b1111; un_sign = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus_req_o && !bus_we_o) begin reached = 1; break; end
    end
    total++; if (reached !== 1) $display("FAIL rstld_ldreq got %0d want 1", reached); else pass_cnt++;
    rst = 1'b0; mem_re = 1'b0;
    #1;
    total++; if ({hold_o, load_valid_o, misalign_o, bus_req_o, bus_we_o, bus_wstrb_o} !== 9'b0 ||
                 rd_wdata_o !== 32'h0 || bus_addr_o !== 32'h0)
      $display("FAIL rstld_outputs ctl=%b rd=%h addr=%h want 0", {hold_o, load_valid_o, misalign_o, bus_req_o, bus_we_o},
               rd_wdata_o, bus_addr_o);
    else pass_cnt++;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin @(negedge clk); #1; if (load_valid_o || bus_req_o) seen++; end
    total++; if (seen !== 0 || log_n !== base) $display("FAIL rstld_quiet active=%0d xfers=%0d want 0/0", seen, log_n - base);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbmem[i] = 32'h0;
    tbmem[0] = 32'h8001_1234;
    bus_ack_i = 1'b0;
    mem_re = 1'b0; mem_we = 1'b0; un_sign = 1'b0;
    mem_raddr = '0; mem_waddr = '0; mem_wdata = '0; byte_sel = 4'b0000;
    test_reset();
    test_sb();
    test_lh(1'b0, 32'hFFFF_8001);
    test_lh(1'b1, 32'h0000_8001);
    test_back_to_back();
    test_sw_lw();
    test_misalign();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end
endmodule
